// File: rtl/text_load_pkg.sv
// Shared types and constants for the display text loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package text_load_pkg;
    localparam int                CHAR_W           = 7;
    localparam logic [2:0]        PHASE_LAST       = 3'd7;
    localparam logic [CHAR_W-1:0] PAD_CODE_DEFAULT = 7'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is held while lock is high.
// Latency: combinational grant, owner registered on the unlocked request cycle.
// Backpressure: lock freezes the grant; commit records the owner as last granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       lock,
    input  logic       commit,
    output logic [1:0] gnt,
    output logic       owner
);
    logic last_q;
    logic owner_q;
    logic pick;

    // Contention goes to whoever was not granted last.
    always_comb begin
        pick = 1'b0;
        if (req == 2'b11)
            pick = ~last_q;
        else if (req[1])
            pick = 1'b1;
    end

    always_comb begin
        gnt = 2'b00;
        if (lock)
            gnt = owner_q ? 2'b10 : 2'b01;
        else if (|req)
            gnt = pick ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q  <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            if (!lock && (|req))
                owner_q <= pick;
            if (commit)
                last_q <= owner_q;
        end
    end

    assign owner = owner_q;
endmodule

// File: rtl/text_load_arb.sv
// Arbitrates two character sources into the serial display text buffer; TEXT_LOAD_PAD_EN pads short messages.
// Latency: grant one cycle after request, then 8-cycle slots per word (bits LSB first, phase 7 commits).
// Backpressure: owner stalls slot phase 0 by dropping rq_valid; rq_ready pulses once per word accepted.
module text_load_arb
    import text_load_pkg::*;
#(
    parameter int                WORD_COUNT = 20,
    parameter logic [CHAR_W-1:0] PAD_CODE   = PAD_CODE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        rq_valid,
    input  logic [CHAR_W-1:0] rq_data0,
    input  logic [CHAR_W-1:0] rq_data1,
    input  logic [1:0]        rq_last,
    output logic [1:0]        rq_ready,
    output logic              disp_write,
    output logic              disp_din,
    output logic              busy,
    output logic              grant_id
);
    localparam int             WCW    = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
    localparam logic [WCW-1:0] WC_MAX = WCW'(WORD_COUNT - 1);

    state_t            state;
    logic [2:0]        phase;
    logic [WCW-1:0]    wcnt;
    logic [CHAR_W-1:0] word_q;
    logic              last_q;
    logic [1:0]        gnt;
    logic              owner;
    logic              own_vld;
    logic              own_last;
    logic              take;
    logic              slot_on;
    logic              msg_end;
    logic [CHAR_W-1:0] own_dat;
    logic [CHAR_W-1:0] slot_word;
    logic [7:0]        slot_bits;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (rq_valid),
        .lock   (state != IDLE),
        .commit (state == DONE),
        .gnt    (gnt),
        .owner  (owner)
    );

    assign own_vld  = rq_valid[owner];
    assign own_last = rq_last[owner];
    assign own_dat  = owner ? rq_data1 : rq_data0;
    assign take     = (state == LOAD) && (phase == 3'd0) && own_vld;
    assign msg_end  = last_q || (wcnt == WC_MAX);

    // Phase 0 shifts the word straight off the bus so the slot starts on the handshake cycle.
    assign slot_on   = (state == PAD) || ((state == LOAD) && ((phase != 3'd0) || own_vld));
    assign slot_word = (state == PAD) ? PAD_CODE : ((phase == 3'd0) ? own_dat : word_q);
    assign slot_bits = {1'b0, slot_word};

    assign rq_ready   = take ? gnt : 2'b00;
    assign disp_write = slot_on;
    assign disp_din   = slot_on & slot_bits[phase];
    assign busy       = (state == LOAD) || (state == PAD);
    assign grant_id   = owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            phase  <= 3'd0;
            wcnt   <= '0;
            word_q <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    phase <= 3'd0;
                    wcnt  <= '0;
                    if (|rq_valid)
                        state <= LOAD;
                end
                LOAD: begin
                    if (phase == 3'd0) begin
                        if (own_vld) begin
                            word_q <= own_dat;
                            last_q <= own_last;
                            phase  <= 3'd1;
                        end
                    end else if (phase == PHASE_LAST) begin
                        phase <= 3'd0;
                        if (msg_end) begin
`ifdef TEXT_LOAD_PAD_EN
                            if (wcnt != WC_MAX) begin
                                state <= PAD;
                                wcnt  <= wcnt + 1'b1;
                            end else begin
                                state <= DONE;
                            end
`else
                            state <= DONE;
`endif
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end else begin
                        phase <= phase + 3'd1;
                    end
                end
`ifdef TEXT_LOAD_PAD_EN
                PAD: begin
                    phase <= phase + 3'd1;
                    if (phase == PHASE_LAST) begin
                        if (wcnt == WC_MAX)
                            state <= DONE;
                        else
                            wcnt <= wcnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    phase <= 3'd0;
                    wcnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_text_load_arb.sv
// Randomized and directed bench for text_load_arb with a message-level reference model.
module tb_text_load_arb;
    localparam int         WC   = 20;
    localparam logic [6:0] PADC = 7'h40;
`ifdef TEXT_LOAD_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] rq_valid;
    logic [6:0] rq_data0;
    logic [6:0] rq_data1;
    logic [1:0] rq_last;
    logic [1:0] rq_ready;
    logic       disp_write;
    logic       disp_din;
    logic       busy;
    logic       grant_id;

    text_load_arb #(.WORD_COUNT(WC), .PAD_CODE(PADC)) dut (
        .clk        (clk),
        .reset      (reset),
        .rq_valid   (rq_valid),
        .rq_data0   (rq_data0),
        .rq_data1   (rq_data1),
        .rq_last    (rq_last),
        .rq_ready   (rq_ready),
        .disp_write (disp_write),
        .disp_din   (disp_din),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int fails     = 0;

    // Monitor: rebuilds displayed words from the serial stream.
    logic [6:0] obs_w[2][$];
    int         obs_msg[2][$];
    int         wr_cycles = 0;
    int         ready_pulses = 0;
    int         bad_ready = 0;
    int         bad_bit7 = 0;
    int         mbit = 0;
    int         cur_len = 0;
    logic [7:0] mbits;
    logic       prev_busy = 1'b0;

    always @(negedge clk or posedge reset) begin
        if (reset) begin
            mbit      = 0;
            cur_len   = 0;
            prev_busy = 1'b0;
        end else begin
            if (disp_write) begin
                wr_cycles++;
                mbits[mbit] = disp_din;
                mbit++;
                if (mbit == 8) begin
                    obs_w[grant_id].push_back(mbits[6:0]);
                    if (mbits[7]) bad_bit7++;
                    mbit = 0;
                    cur_len++;
                end
            end
            if (prev_busy && !busy) begin
                obs_msg[grant_id].push_back(cur_len);
                cur_len = 0;
            end
            prev_busy = busy;
            for (int i = 0; i < 2; i++) begin
                if (rq_ready[i]) begin
                    ready_pulses++;
                    if (!busy || (grant_id != 1'(i))) bad_ready++;
                end
            end
        end
    end

    // Requester side: per-requester word queues, {last, data}.
    logic [7:0] q[2][$];
    int         hs_who[$];

    task automatic drive_heads(input int gap_pct);
        for (int i = 0; i < 2; i++) begin
            if (q[i].size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                rq_valid[i] = 1'b1;
                rq_last[i]  = q[i][0][7];
                if (i == 0) rq_data0 = q[i][0][6:0];
                else        rq_data1 = q[i][0][6:0];
            end else begin
                rq_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic sample_hs();
        for (int i = 0; i < 2; i++) begin
            if (rq_valid[i] && rq_ready[i]) begin
                hs_who.push_back(i);
                void'(q[i].pop_front());
            end
        end
    endtask

    task automatic run_traffic(input int budget, input int gap_pct, output bit done);
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk); #1;
            drive_heads(gap_pct);
            @(negedge clk);
            sample_hs();
            if (q[0].size() == 0 && q[1].size() == 0 && !busy) done = 1'b1;
        end
        rq_valid = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic apply_reset();
        reset    = 1'b1;
        rq_valid = 2'b00;
        rq_last  = 2'b00;
        q[0].delete();
        q[1].delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rq_valid = 2'b11;
        rq_last  = 2'b11;
        rq_data0 = 7'h7f;
        rq_data1 = 7'h55;
        @(posedge clk); #1;
        tests_run++; if (rq_ready !== 2'b00) begin fails++; $display("FAIL reset_rq_ready got=%b exp=00", rq_ready); end
        tests_run++; if (disp_write !== 1'b0) begin fails++; $display("FAIL reset_disp_write got=%b exp=0", disp_write); end
        tests_run++; if (disp_din !== 1'b0) begin fails++; $display("FAIL reset_disp_din got=%b exp=0", disp_din); end
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests_run++; if (grant_id !== 1'b0) begin fails++; $display("FAIL reset_grant_id got=%b exp=0", grant_id); end
        rq_valid = 2'b00;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || disp_write !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset busy=%b write=%b exp 0/0", busy, disp_write);
        end
    endtask

    task automatic test_single_word();
        logic [6:0] w;
        logic       exp_din;
        w = 7'h21;
        @(posedge clk); #1;
        rq_data0 = w; rq_last = 2'b01; rq_valid = 2'b01;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0) begin fails++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_din = (k < 7) ? w[k] : 1'b0;
            tests_run++;
            if (disp_write !== 1'b1 || disp_din !== exp_din) begin
                fails++; $display("FAIL single_bit%0d write=%b din=%b exp write=1 din=%b", k, disp_write, disp_din, exp_din);
            end
            if (k == 0) begin
                tests_run++; if (rq_ready !== 2'b01) begin fails++; $display("FAIL single_ready got=%b exp=01", rq_ready); end
                @(posedge clk); #1 rq_valid = 2'b00;
            end
        end
        @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || disp_write !== 1'b0) begin
            fails++; $display("FAIL single_done busy=%b write=%b exp 0/0", busy, disp_write);
        end
    endtask

    task automatic test_arbitration();
        int hs0, br0, w1;
        bit done;
        apply_reset();
        q[0].push_back({1'b1, 7'h15});
        q[1].push_back({1'b1, 7'h6A});
        hs0 = hs_who.size(); br0 = bad_ready; w1 = obs_w[1].size();
        run_traffic(100, 0, done);
        tests_run++; if (!done) begin fails++; $display("FAIL arb_timeout done=%0d exp=1", done); end
        tests_run++; if (hs_who.size() - hs0 != 2) begin fails++; $display("FAIL arb_hs_count got=%0d exp=2", hs_who.size() - hs0); end
        tests_run++; if (hs_who.size() - hs0 < 2 || hs_who[hs0] != 0 || hs_who[hs0+1] != 1) begin
            fails++; $display("FAIL arb_order first=%0d second=%0d exp 0 then 1", hs_who[hs0], hs_who[hs0+1]);
        end
        tests_run++; if (bad_ready != br0) begin fails++; $display("FAIL arb_foreign_ready got=%0d exp=0", bad_ready - br0); end
        tests_run++; if (obs_w[1].size() - w1 != 1 || obs_w[1][w1] !== 7'h6A) begin
            fails++; $display("FAIL arb_req1_word got=%h exp=6a", obs_w[1][w1]);
        end
    endtask

    task automatic test_overflow();
        logic [6:0] sent[$];
        int hs0, m0, w0, wr0, nbad;
        bit done;
        apply_reset();
        for (int k = 0; k < 25; k++) begin
            sent.push_back(7'($urandom_range(127)));
            q[0].push_back({1'b0, sent[k]});
        end
        hs0 = hs_who.size(); m0 = obs_msg[0].size(); w0 = obs_w[0].size(); wr0 = wr_cycles;
        run_traffic(300, 0, done);
        tests_run++; if (done) begin fails++; $display("FAIL ovf_still_waiting done=%0d exp=0", done); end
        tests_run++; if (hs_who.size() - hs0 != 25) begin fails++; $display("FAIL ovf_hs got=%0d exp=25", hs_who.size() - hs0); end
        tests_run++; if (obs_msg[0].size() - m0 != 1 || obs_msg[0][m0] != WC) begin
            fails++; $display("FAIL ovf_msg_len n=%0d len=%0d exp 1 msg of %0d", obs_msg[0].size() - m0, obs_msg[0][m0], WC);
        end
        tests_run++; if (wr_cycles - wr0 != 25 * 8) begin fails++; $display("FAIL ovf_writes got=%0d exp=%0d", wr_cycles - wr0, 25 * 8); end
        nbad = 0;
        for (int k = 0; k < 25; k++) if (obs_w[0].size() <= w0 + k || obs_w[0][w0+k] !== sent[k]) nbad++;
        tests_run++; if (nbad != 0) begin fails++; $display("FAIL ovf_words bad=%0d exp=0", nbad); end
        tests_run++; if (busy !== 1'b1 || disp_write !== 1'b0) begin
            fails++; $display("FAIL ovf_stalled busy=%b write=%b exp 1/0", busy, disp_write);
        end
    endtask

    task automatic test_stall();
        logic [6:0] a, b;
        int w0, wr0, got;
        a = 7'h5A; b = 7'h33;
        apply_reset();
        w0 = obs_w[0].size(); wr0 = wr_cycles;
        @(posedge clk); #1;
        rq_data0 = a; rq_last = 2'b00; rq_valid = 2'b01;
        got = 0;
        for (int c = 0; c < 10 && got == 0; c++) begin
            @(negedge clk);
            if (rq_ready[0]) got = 1;
        end
        tests_run++; if (got != 1) begin fails++; $display("FAIL stall_first_hs got=%0d exp=1", got); end
        @(posedge clk); #1 rq_valid = 2'b00;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            tests_run++; if (disp_write !== 1'b1) begin fails++; $display("FAIL stall_slot_ph%0d write=%b exp=1", k + 1, disp_write); end
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests_run++;
            if (disp_write !== 1'b0 || busy !== 1'b1 || rq_ready !== 2'b00) begin
                fails++; $display("FAIL stall_hold%0d write=%b busy=%b ready=%b exp 0/1/00", k, disp_write, busy, rq_ready);
            end
        end
        @(posedge clk); #1;
        rq_data0 = b; rq_last = 2'b01; rq_valid = 2'b01;
        @(negedge clk);
        tests_run++;
        if (rq_ready !== 2'b01 || disp_write !== 1'b1 || disp_din !== b[0]) begin
            fails++; $display("FAIL stall_resume ready=%b write=%b din=%b exp 01/1/%b", rq_ready, disp_write, disp_din, b[0]);
        end
        @(posedge clk); #1 rq_valid = 2'b00;
        got = 0;
        for (int c = 0; c < 40 && got == 0; c++) begin
            @(negedge clk);
            if (!busy) got = 1;
        end
        repeat (2) @(negedge clk);
        tests_run++; if (got != 1) begin fails++; $display("FAIL stall_end got=%0d exp=1", got); end
        tests_run++;
        if (obs_w[0].size() - w0 != 2 || obs_w[0][w0] !== a || obs_w[0][w0+1] !== b || wr_cycles - wr0 != 16) begin
            fails++; $display("FAIL stall_words n=%0d w0=%h w1=%h wr=%0d exp 2/%h/%h/16",
                              obs_w[0].size() - w0, obs_w[0][w0], obs_w[0][w0+1], wr_cycles - wr0, a, b);
        end
    endtask

    task automatic test_reset_midslot();
        int nw, m0, rp0;
        bit done;
        apply_reset();
        for (int k = 0; k < 5; k++) q[1].push_back({(k == 4), 7'(k + 1)});
        nw = 0;
        for (int c = 0; c < 100 && nw < 20; c++) begin
            @(posedge clk); #1;
            drive_heads(0);
            @(negedge clk);
            sample_hs();
            if (disp_write) nw++;
        end
        tests_run++; if (nw != 20 || grant_id !== 1'b1) begin fails++; $display("FAIL mid_reach nw=%0d grant=%b exp 20/1", nw, grant_id); end
        reset = 1'b1;
        #1;
        tests_run++;
        if (rq_ready !== 2'b00 || disp_write !== 1'b0 || disp_din !== 1'b0 || busy !== 1'b0 || grant_id !== 1'b0) begin
            fails++; $display("FAIL mid_reset_outputs ready=%b write=%b din=%b busy=%b grant=%b exp all 0",
                              rq_ready, disp_write, disp_din, busy, grant_id);
        end
        rq_valid = 2'b00;
        q[1].delete();
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        tests_run++; if (busy !== 1'b0 || disp_write !== 1'b0) begin fails++; $display("FAIL mid_idle busy=%b write=%b exp 0/0", busy, disp_write); end
        for (int k = 0; k < WC; k++) q[1].push_back({1'b0, 7'(k + 64)});
        m0 = obs_msg[1].size(); rp0 = ready_pulses;
        run_traffic(400, 10, done);
        tests_run++; if (!done) begin fails++; $display("FAIL mid_restart_timeout done=%0d exp=1", done); end
        tests_run++; if (obs_msg[1].size() - m0 != 1 || obs_msg[1][m0] != WC || ready_pulses - rp0 != WC) begin
            fails++; $display("FAIL mid_restart_len n=%0d len=%0d pulses=%0d exp 1/%0d/%0d",
                              obs_msg[1].size() - m0, obs_msg[1][m0], ready_pulses - rp0, WC, WC);
        end
    endtask

    task automatic test_random();
        logic [6:0] ew[2][$];
        int         em[2][$];
        int ws[2], ms[2];
        int n, len, tot_sent, tot_words, tot_msgs, wr0, rp0, br0, b70, nbad, budget;
        bit done, lst;
        for (int r = 0; r < 3; r++) begin
            tot_sent = 0; tot_words = 0; tot_msgs = 0;
            for (int i = 0; i < 2; i++) begin
                ew[i].delete(); em[i].delete();
                n = (i == 0) ? int'($urandom_range(1, 28)) : int'($urandom_range(0, 28));
                len = 0;
                for (int k = 0; k < n; k++) begin
                    lst = (k == n - 1) || ($urandom_range(99) < 15);
                    q[i].push_back({lst, 7'($urandom_range(127))});
                    ew[i].push_back(q[i][k][6:0]);
                    len++;
                    if (lst || len == WC) begin
                        if (PAD_ON) while (len < WC) begin ew[i].push_back(PADC); len++; end
                        em[i].push_back(len);
                        len = 0;
                    end
                end
                tot_sent += n;
                tot_words += ew[i].size();
                tot_msgs += em[i].size();
                ws[i] = obs_w[i].size();
                ms[i] = obs_msg[i].size();
            end
            wr0 = wr_cycles; rp0 = ready_pulses; br0 = bad_ready; b70 = bad_bit7;
            budget = 12 * tot_words + 20 * tot_msgs + 100;
            run_traffic(budget, 20, done);
            tests_run++; if (!done) begin fails++; $display("FAIL rnd%0d_timeout done=%0d exp=1", r, done); end
            for (int i = 0; i < 2; i++) begin
                tests_run++;
                if (obs_w[i].size() - ws[i] != ew[i].size()) begin
                    fails++; $display("FAIL rnd%0d_req%0d_nwords got=%0d exp=%0d", r, i, obs_w[i].size() - ws[i], ew[i].size());
                end else begin
                    nbad = 0;
                    for (int k = 0; k < ew[i].size(); k++) if (obs_w[i][ws[i]+k] !== ew[i][k]) nbad++;
                    tests_run++; if (nbad != 0) begin fails++; $display("FAIL rnd%0d_req%0d_words bad=%0d exp=0", r, i, nbad); end
                end
                nbad = 0;
                if (obs_msg[i].size() - ms[i] != em[i].size()) nbad = 1;
                else for (int k = 0; k < em[i].size(); k++) if (obs_msg[i][ms[i]+k] != em[i][k]) nbad++;
                tests_run++; if (nbad != 0) begin
                    fails++; $display("FAIL rnd%0d_req%0d_msgs got_n=%0d exp_n=%0d bad=%0d", r, i, obs_msg[i].size() - ms[i], em[i].size(), nbad);
                end
            end
            tests_run++; if (wr_cycles - wr0 != 8 * tot_words) begin fails++; $display("FAIL rnd%0d_writes got=%0d exp=%0d", r, wr_cycles - wr0, 8 * tot_words); end
            tests_run++; if (ready_pulses - rp0 != tot_sent) begin fails++; $display("FAIL rnd%0d_pulses got=%0d exp=%0d", r, ready_pulses - rp0, tot_sent); end
            tests_run++; if (bad_ready != br0 || bad_bit7 != b70) begin
                fails++; $display("FAIL rnd%0d_protocol foreign_ready=%0d bit7=%0d exp 0/0", r, bad_ready - br0, bad_bit7 - b70);
            end
        end
    endtask

    initial begin
        rq_valid = 2'b00;
        rq_last  = 2'b00;
        rq_data0 = 7'h00;
        rq_data1 = 7'h00;
        test_reset();
        if (!PAD_ON) test_single_word();
        test_arbitration();
        if (!PAD_ON) test_overflow();
        test_stall();
        test_reset_midslot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/text_load_arb.md
TEXT_LOAD_ARB -- requirements
Module: text_load_arb

Interface
REQ-001 The block SHALL have parameter WORD_COUNT, default 20, which sets the number of 7-bit character words in the downstream display text buffer.
REQ-002 The block SHALL have parameter PAD_CODE, default 7'h40, which is the blank glyph code used for padding.
REQ-003 Port clk, input, 1: clock, rising-edge active.
REQ-004 Port reset, input, 1: reset, asynchronous, active-high.
REQ-005 Port rq_valid, input, 2: per-requester word valid.
REQ-006 Port rq_data0, input, 7: character word from requester 0.
REQ-007 Port rq_data1, input, 7: character word from requester 1.
REQ-008 Port rq_last, input, 2: per-requester last-word-of-message flag, qualified by rq_valid.
REQ-009 Port rq_ready, output, 2: per-requester word accepted this cycle.
REQ-010 Port disp_write, output, 1: drives the display buffer write input.
REQ-011 Port disp_din, output, 1: drives the display buffer serial data input.
REQ-012 Port busy, output, 1: a message is being loaded.
REQ-013 Port grant_id, output, 1: index of the current or most recent owner.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, PAD and DONE.
REQ-015 IDLE: disp_write=0; when any rq_valid is high, go to LOAD next cycle with the owner chosen round-robin. Priority goes to the requester not granted last; requester 0 wins after reset.
REQ-016 The grant SHALL stay locked to one owner for a whole message. The other requester's rq_ready SHALL stay 0 until the FSM returns to IDLE.
REQ-017 Word slot: a 3-bit phase counter counts 0..7. disp_write=1 in all 8 phases.
REQ-018 In phases 0..6, disp_din SHALL carry the word bits LSB first (bit[phase]). In phase 7, disp_din=0 and the display commits and rotates one word.
REQ-019 LOAD: at phase 0, if the owner's rq_valid=1, capture the word and pulse rq_ready for one cycle.
REQ-020 LOAD stall: if the owner's rq_valid=0 at phase 0, the block SHALL hold the phase counter at 0 with disp_write=0 until the owner's rq_valid is high.
REQ-021 The block SHALL keep a word counter from 0 to WORD_COUNT-1, incremented at each phase 7.
REQ-022 The message SHALL end on the earlier of a captured rq_last=1 or word counter = WORD_COUNT-1. Words offered after WORD_COUNT words SHALL wait for the next message.
REQ-023 After the message ends: go to PAD if PAD_EN is defined and fewer than WORD_COUNT words were sent, otherwise go to DONE.
REQ-024 PAD: send PAD_CODE words with the same slot timing until WORD_COUNT words in total have been sent, then go to DONE. rq_ready SHALL stay 0 during PAD.
REQ-025 DONE: one cycle with disp_write=0 and busy=0, update the last-granted record, then go to IDLE.
REQ-026 busy SHALL be 1 in LOAD and PAD, and 0 in IDLE and DONE.
REQ-027 Simultaneous rq_valid from both requesters in IDLE SHALL be resolved by REQ-015 in the same cycle.
REQ-028 A requester that deasserts rq_valid without a handshake SHALL lose nothing.

Reset
REQ-029 On reset the block SHALL enter IDLE and clear the phase counter and word counter.
REQ-030 Reset values: rq_ready=0, disp_write=0, disp_din=0, busy=0, grant_id=0, last-granted=1 (so requester 0 wins first).
REQ-031 Reset mid-slot SHALL abandon the partial word immediately; the next message restarts at word 0.

Configuration
REQ-032 Macro TEXT_LOAD_PAD_EN defined: short messages SHALL be padded per REQ-024, so the display buffer always realigns to word 0.
REQ-033 Macro TEXT_LOAD_PAD_EN undefined: the PAD state SHALL be absent, and the FSM goes from LOAD to DONE after the last word.

Structure
REQ-034 Package text_load_pkg SHALL hold the FSM state enum, the CHAR_W=7 constant, the PHASE_LAST=3'd7 constant and the PAD_CODE default.
REQ-035 A sub-module rr_arb2 SHALL be used: a 2-way round-robin arbiter with a lock input, outputting a one-hot grant.

Verification
REQ-036 Single word 7'h21 from requester 0 with rq_last=1, PAD_EN off -> disp_din sequence 1,0,0,0,0,1,0,0 over 8 cycles with disp_write=1, then DONE and busy=0 on cycle 9.
REQ-037 Both requesters valid in IDLE after reset -> requester 0 is granted first; after its message ends, requester 1 is granted; rq_ready[1]=0 throughout the first message.
REQ-038 3-word message with PAD_EN on, WORD_COUNT=20 -> 17 PAD_CODE words follow, for 160 write-high cycles in total.
REQ-039 25 valid words with no rq_last -> exactly 20 rq_ready pulses, then DONE; the 21st word is accepted as word 0 of the next message.
REQ-040 Owner drops rq_valid for 5 cycles at phase 0 -> disp_write=0 and the phase is held for those 5 cycles, then loading resumes with no bit lost.
REQ-041 Reset asserted at phase 3 of word 2 -> all outputs return to reset values within the same cycle, and IDLE is reached.
